painterengine_gpu_blend_writer: RTL and testbench
=================================================

Name: painterengine_gpu_blend_writer

Overview:
Sink for the blended pixel stream produced by the GPU blender stage. The stream carries 32-bit pixel plus valid and has no backpressure. The block buffers pixels in an internal FIFO and writes them to a destination rectangle in memory as row-bounded bursts over a request/ack + valid/ready write interface. It pulses done once width*height pixels have been written.

Parameters:
FIFO_DEPTH, 64, pixel buffer depth; power of 2, >= BURST_LEN
BURST_LEN, 16, maximum beats per write burst; 1..255

Ports:
i_wire_clock  in  1  clock
i_wire_resetn  in  1  asynchronous active-low reset
i_wire_start  in  1  one-cycle start pulse; sampled only in IDLE
i_wire_dst_addr  in  32  byte address of pixel (0,0); 4-byte aligned
i_wire_width  in  16  pixels per row
i_wire_height  in  16  rows
i_wire_stride  in  32  bytes between row starts
i_wire_data_in  in  32  blended pixel
i_wire_data_valid  in  1  pixel valid; no backpressure
o_wire_wr_req  out  1  burst request
o_wire_wr_addr  out  32  burst start byte address
o_wire_wr_len  out  8  burst beats
i_wire_wr_ack  in  1  request accepted when req&ack
o_wire_wr_data  out  32  write beat data (FIFO head)
o_wire_wr_data_valid  out  1  beat valid
i_wire_wr_data_ready  in  1  beat accepted when valid&ready
o_wire_busy  out  1  job in progress
o_wire_done  out  1  one-cycle completion pulse
o_wire_overflow  out  1  sticky: pixel dropped because FIFO full

Behaviour:
- Reset: asynchronous, active-low, effective at any time including mid-burst. All outputs 0; state IDLE; FIFO empty; counters 0.
- States: IDLE, REQ, DATA, DONE.
- IDLE + start: latch dst_addr/width/height/stride, flush FIFO, clear overflow, zero pixel/column/row counters. Go to REQ, or to DONE if width==0 or height==0. busy=1 from the next cycle until DONE exits. start outside IDLE is ignored.
- Pixel accept: while busy, a pixel with valid=1 is pushed if the FIFO is not full and the accepted count < width*height.
  - Valid with FIFO full and no same-cycle pop: pixel dropped, overflow set.
  - Valid with FIFO full and same-cycle pop: pixel accepted, count unchanged.
  - Valid while IDLE/DONE, or beyond width*height accepted pixels: ignored, no overflow.
- Burst length = min(BURST_LEN, width - col). Bursts never cross a row.
- Burst address = row_base + col*4. row_base starts at dst_addr and advances by stride per row; 32-bit arithmetic, wraps mod 2^32.
- REQ: req asserts only when FIFO count >= burst length. addr/len are held stable while req=1. req&ack in the same cycle -> DATA, req drops the next cycle.
- DATA:
  - wr_data_valid = FIFO non-empty; wr_data = FIFO head (first-word fall-through).
  - Each valid&ready pops one pixel and counts one beat.
  - On the last beat: col += len. If col==width: col=0, row+1, row_base+=stride.
  - Then, if row==height -> DONE, else -> REQ. The next REQ may assert the cycle after the last beat.
- DONE: done=1 for exactly one cycle, then IDLE; busy=0 in IDLE. The overflow flag persists until the next start.
- Latency: start at cycle T gives busy=1 at T+1. The earliest req is T+2 (first pixel valid at T+1), once count >= len.
- wr_data_valid=0 outside DATA. wr_data is don't-care when valid=0.

Test Plan:
- BURST_LEN=16, dst=0x1000, w=4, h=2, stride=0x40, pixels 0x01..0x08 back-to-back, ack/ready tied 1 -> req (0x1000, len 4) beats 01..04, then req (0x1040, len 4) beats 05..08, one done pulse, overflow=0.
- w=40, h=1, dst=0 -> bursts (0x00,16), (0x40,16), (0x80,8). Data order preserved. No req while FIFO count < len.
- w=4, h=1, ready toggling 1/0 every cycle -> 4 beats over 8 cycles, data 0xA0..0xA3 in order, valid held through stalls, done after 4th beat.
- FIFO_DEPTH=64, ack held 0, 65 pixels pushed (w=128, h=1) -> overflow=1; FIFO holds pixels 0..63; 65th dropped. After releasing ack, the first burst data = pixels 0..15.
- start with w=0, h=5 -> done pulse 2 cycles after start, no req ever. Second start while busy -> ignored, latched dims unchanged.
- Reset asserted mid-DATA after 3 of 16 beats -> all outputs 0 immediately. A fresh job after reset runs normally from an empty FIFO.

Source files
------------

// File: rtl/painterengine_gpu_blend_writer_if.sv
// Write-side bus of the blend writer: burst request/ack plus beat valid/ready.
// Master is the writer, slave is the memory port.
interface painterengine_gpu_blend_writer_if;
    logic        o_wire_wr_req;
    logic [31:0] o_wire_wr_addr;
    logic [7:0]  o_wire_wr_len;
    logic        i_wire_wr_ack;
    logic [31:0] o_wire_wr_data;
    logic        o_wire_wr_data_valid;
    logic        i_wire_wr_data_ready;

    modport master (
        output o_wire_wr_req,
        output o_wire_wr_addr,
        output o_wire_wr_len,
        output o_wire_wr_data,
        output o_wire_wr_data_valid,
        input  i_wire_wr_ack,
        input  i_wire_wr_data_ready
    );

    modport slave (
        input  o_wire_wr_req,
        input  o_wire_wr_addr,
        input  o_wire_wr_len,
        input  o_wire_wr_data,
        input  o_wire_wr_data_valid,
        output i_wire_wr_ack,
        output i_wire_wr_data_ready
    );
endinterface

// File: rtl/painterengine_gpu_blend_writer.sv
// Buffers the blended pixel stream in a FIFO and writes it to a destination
// rectangle as row-bounded bursts; pulses done after width*height pixels.
module painterengine_gpu_blend_writer #(
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN  = 16
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_start,
    input  logic [31:0] i_wire_dst_addr,
    input  logic [15:0] i_wire_width,
    input  logic [15:0] i_wire_height,
    input  logic [31:0] i_wire_stride,
    input  logic [31:0] i_wire_data_in,
    input  logic        i_wire_data_valid,
    painterengine_gpu_blend_writer_if.master wr_bus,
    output logic        o_wire_busy,
    output logic        o_wire_done,
    output logic        o_wire_overflow
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] PTR_ZERO  = (AW+1)'(0);
    localparam logic [7:0]  BURST_C   = 8'(BURST_LEN);
    localparam logic [15:0] BURST16_C = 16'(BURST_LEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [31:0] stride_q, stride_d;
    logic [31:0] row_base_q, row_base_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] total_q, total_d;
    logic [31:0] accepted_q, accepted_d;
    logic        overflow_q, overflow_d;
    logic        busy_q;
    logic        done_q;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] fifo_mem_q [FIFO_DEPTH];

    logic [AW:0] fifo_cnt_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic [15:0] rem_s;
    logic [7:0]  burst_len_s;
    logic [31:0] burst_addr_s;
    logic        req_s;
    logic        ack_s;
    logic        accepting_s;
    logic        pop_s;
    logic        push_s;
    logic        drop_s;
    logic        last_beat_s;
    logic [15:0] col_sum_s;
    logic        row_end_s;
    logic [15:0] row_next_s;

    assign fifo_cnt_s   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty_s = (fifo_cnt_s == PTR_ZERO);
    assign fifo_full_s  = (fifo_cnt_s == DEPTH_C);

    // A burst is clipped to the end of the current row.
    assign rem_s        = width_q - col_q;
    assign burst_len_s  = (rem_s > BURST16_C) ? BURST_C : rem_s[7:0];
    assign burst_addr_s = row_base_q + {14'd0, col_q, 2'b00};

    // Only request once the whole burst is already buffered, so beats never starve.
    assign req_s       = (state_q == ST_REQ) && (32'(fifo_cnt_s) >= {24'd0, burst_len_s});
    assign ack_s       = req_s && wr_bus.i_wire_wr_ack;
    assign pop_s       = (state_q == ST_DATA) && !fifo_empty_s && wr_bus.i_wire_wr_data_ready;
    assign accepting_s = ((state_q == ST_REQ) || (state_q == ST_DATA)) && i_wire_data_valid
                         && (accepted_q < total_q);
    assign push_s      = accepting_s && (!fifo_full_s || pop_s);
    assign drop_s      = accepting_s && fifo_full_s && !pop_s;
    assign last_beat_s = pop_s && (beat_q == (burst_len_s - 8'd1));
    assign col_sum_s   = col_q + {8'd0, burst_len_s};
    assign row_end_s   = (col_sum_s == width_q);
    assign row_next_s  = row_end_s ? (row_q + 16'd1) : row_q;

    // Next-state logic for the FSM, job registers and FIFO pointers.
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        row_d      = row_q;
        beat_d     = beat_q;
        total_d    = total_q;
        accepted_d = push_s ? (accepted_q + 32'd1) : accepted_q;
        overflow_d = drop_s ? 1'b1 : overflow_q;
        wr_ptr_d   = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (i_wire_start) begin
                    width_d    = i_wire_width;
                    height_d   = i_wire_height;
                    stride_d   = i_wire_stride;
                    row_base_d = i_wire_dst_addr;
                    col_d      = 16'd0;
                    row_d      = 16'd0;
                    beat_d     = 8'd0;
                    total_d    = {16'd0, i_wire_width} * {16'd0, i_wire_height};
                    accepted_d = 32'd0;
                    overflow_d = 1'b0;
                    wr_ptr_d   = PTR_ZERO;
                    rd_ptr_d   = PTR_ZERO;
                    if ((i_wire_width == 16'd0) || (i_wire_height == 16'd0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_d = ST_DATA;
                    beat_d  = 8'd0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DATA: begin
                if (last_beat_s) begin
                    beat_d = 8'd0;
                    row_d  = row_next_s;
                    if (row_end_s) begin
                        col_d      = 16'd0;
                        row_base_d = row_base_q + stride_q;
                    end else begin
                        col_d = col_sum_s;
                    end
                    state_d = (row_next_s == height_q) ? ST_DONE : ST_REQ;
                end else if (pop_s) begin
                    beat_d = beat_q + 8'd1;
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset clears everything, including mid-burst.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q    <= ST_IDLE;
            width_q    <= 16'd0;
            height_q   <= 16'd0;
            stride_q   <= 32'd0;
            row_base_q <= 32'd0;
            col_q      <= 16'd0;
            row_q      <= 16'd0;
            beat_q     <= 8'd0;
            total_q    <= 32'd0;
            accepted_q <= 32'd0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            row_q      <= row_d;
            beat_q     <= beat_d;
            total_q    <= total_d;
            accepted_q <= accepted_d;
            overflow_q <= overflow_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_q == ST_DONE);
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Pixel storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge i_wire_clock) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= i_wire_data_in;
        end
    end

    assign wr_bus.o_wire_wr_req        = req_s;
    assign wr_bus.o_wire_wr_addr       = req_s ? burst_addr_s : 32'd0;
    assign wr_bus.o_wire_wr_len        = req_s ? burst_len_s : 8'd0;
    assign wr_bus.o_wire_wr_data_valid = (state_q == ST_DATA) && !fifo_empty_s;
    assign wr_bus.o_wire_wr_data       = wr_bus.o_wire_wr_data_valid ?
                                         fifo_mem_q[rd_ptr_q[AW-1:0]] : 32'd0;
    assign o_wire_busy     = busy_q;
    assign o_wire_done     = done_q;
    assign o_wire_overflow = overflow_q;
endmodule

// File: tb/tb_painterengine_gpu_blend_writer.sv
// Directed bench for the blend writer: expected bursts and beats are queued
// when stimulus is driven and compared as the DUT emits them.
module tb_painterengine_gpu_blend_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dst = 32'd0;
    logic [15:0] w = 16'd0;
    logic [15:0] h = 16'd0;
    logic [31:0] stride = 32'd0;
    logic [31:0] din = 32'd0;
    logic        dvalid = 1'b0;
    logic        busy, done, ovf;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_req[$];
    logic [31:0] exp_dat[$];
    int done_cnt = 0;
    int req_cycles = 0;
    int beat_cnt = 0;
    int in_cnt = 0;
    int job_beats = 0;
    bit lvl_chk_en = 1'b0;
    logic        prev_req, prev_ack, prev_valid, prev_ready;
    logic [31:0] prev_addr, prev_data;
    logic [7:0]  prev_len;
    logic [39:0] req_item;
    logic [31:0] dat_item;

    painterengine_gpu_blend_writer_if wr_bus();

    painterengine_gpu_blend_writer #(.FIFO_DEPTH(64), .BURST_LEN(16)) dut (
        .i_wire_clock      (clk),
        .i_wire_resetn     (rst_n),
        .i_wire_start      (start),
        .i_wire_dst_addr   (dst),
        .i_wire_width      (w),
        .i_wire_height     (h),
        .i_wire_stride     (stride),
        .i_wire_data_in    (din),
        .i_wire_data_valid (dvalid),
        .wr_bus            (wr_bus.master),
        .o_wire_busy       (busy),
        .o_wire_done       (done),
        .o_wire_overflow   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req   <= 1'b0;
            prev_ack   <= 1'b0;
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_addr  <= 32'd0;
            prev_len   <= 8'd0;
            prev_data  <= 32'd0;
        end else begin
            if (wr_bus.o_wire_wr_req) req_cycles <= req_cycles + 1;
            if (prev_req && !prev_ack && wr_bus.o_wire_wr_req)
                chk("req_stable", {wr_bus.o_wire_wr_addr, wr_bus.o_wire_wr_len}, {prev_addr, prev_len});
            if (lvl_chk_en && wr_bus.o_wire_wr_req)
                chk("req_fifo_level", ((in_cnt - job_beats) >= int'(wr_bus.o_wire_wr_len)) ? 1 : 0, 1);
            if (wr_bus.o_wire_wr_req && wr_bus.i_wire_wr_ack) begin
                if (exp_req.size() == 0) chk("unexpected_req", {wr_bus.o_wire_wr_addr, wr_bus.o_wire_wr_len}, 0);
                else begin
                    req_item = exp_req.pop_front();
                    chk("req_addr_len", {wr_bus.o_wire_wr_addr, wr_bus.o_wire_wr_len}, req_item);
                end
            end
            if (prev_valid && !prev_ready)
                chk("stall_hold", {wr_bus.o_wire_wr_data_valid, wr_bus.o_wire_wr_data}, {1'b1, prev_data});
            if (wr_bus.o_wire_wr_data_valid && wr_bus.i_wire_wr_data_ready) begin
                beat_cnt <= beat_cnt + 1;
                if (exp_dat.size() == 0) chk("unexpected_beat", wr_bus.o_wire_wr_data, 0);
                else begin
                    dat_item = exp_dat.pop_front();
                    chk("beat_data", wr_bus.o_wire_wr_data, dat_item);
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                chk("done_after_all_beats", exp_dat.size(), 0);
            end
            if (lvl_chk_en) begin
                in_cnt    <= in_cnt + (dvalid ? 1 : 0);
                job_beats <= job_beats + ((wr_bus.o_wire_wr_data_valid && wr_bus.i_wire_wr_data_ready) ? 1 : 0);
            end
            prev_req   <= wr_bus.o_wire_wr_req;
            prev_ack   <= wr_bus.i_wire_wr_ack;
            prev_addr  <= wr_bus.o_wire_wr_addr;
            prev_len   <= wr_bus.o_wire_wr_len;
            prev_valid <= wr_bus.o_wire_wr_data_valid;
            prev_ready <= wr_bus.i_wire_wr_data_ready;
            prev_data  <= wr_bus.o_wire_wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] a, input logic [15:0] ww, input logic [15:0] hh,
                             input logic [31:0] s);
        dst = a; w = ww; h = hh; stride = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_pixels(input logic [31:0] base, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            din = base + 32'(i);
            dvalid = 1'b1;
            tick();
            dvalid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
        dvalid = 1'b0;
    endtask

    task automatic expect_burst(input logic [31:0] a, input logic [7:0] len, input logic [31:0] base);
        exp_req.push_back({a, len});
        for (int i = 0; i < int'(len); i++) exp_dat.push_back(base + 32'(i));
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done_cnt - d0, 1);
        tick();
        tick();
        chk({tag, "_single"}, done_cnt - d0, 1);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (beat_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (beat_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!wr_bus.o_wire_wr_data_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, wr_bus.o_wire_wr_data_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int b0;
        int r0;
        wr_bus.i_wire_wr_ack = 1'b0;
        wr_bus.i_wire_wr_data_ready = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {wr_bus.o_wire_wr_req, wr_bus.o_wire_wr_addr, wr_bus.o_wire_wr_len,
                              wr_bus.o_wire_wr_data_valid, busy, done, ovf}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", {busy, done, ovf, wr_bus.o_wire_wr_req}, 0);

        // Two-row job, ack/ready always high.
        wr_bus.i_wire_wr_ack = 1'b1;
        wr_bus.i_wire_wr_data_ready = 1'b1;
        expect_burst(32'h1000, 8'd4, 32'h01);
        expect_burst(32'h1040, 8'd4, 32'h05);
        d0 = done_cnt;
        start_job(32'h1000, 16'd4, 16'd2, 32'h40);
        chk("busy_t1", busy, 1);
        push_pixels(32'h01, 8, 0);
        wait_done("t1_done", d0, 100);
        chk("t1_overflow", ovf, 0);
        chk("t1_busy_after", busy, 0);

        // 40-wide row split into 16/16/8 with sparse input.
        expect_burst(32'h00, 8'd16, 32'h200);
        expect_burst(32'h40, 8'd16, 32'h210);
        expect_burst(32'h80, 8'd8, 32'h220);
        in_cnt = 0;
        job_beats = 0;
        lvl_chk_en = 1'b1;
        d0 = done_cnt;
        start_job(32'h0, 16'd40, 16'd1, 32'h0);
        push_pixels(32'h200, 40, 1);
        wait_done("t2_done", d0, 200);
        lvl_chk_en = 1'b0;

        // Ready toggling every cycle.
        wr_bus.i_wire_wr_data_ready = 1'b0;
        expect_burst(32'h2000, 8'd4, 32'hA0);
        d0 = done_cnt;
        start_job(32'h2000, 16'd4, 16'd1, 32'h0);
        push_pixels(32'hA0, 4, 0);
        wait_valid("t3_valid", 20);
        b0 = beat_cnt;
        for (int i = 0; i < 8; i++) begin
            wr_bus.i_wire_wr_data_ready = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        wr_bus.i_wire_wr_data_ready = 1'b1;
        chk("t3_beats_in_8", beat_cnt - b0, 4);
        wait_done("t3_done", d0, 20);

        // Overflow: ack held low while 65 pixels arrive.
        wr_bus.i_wire_wr_ack = 1'b0;
        for (int k = 0; k < 4; k++) expect_burst(32'h3000 + 32'(k * 64), 8'd16, 32'h300 + 32'(k * 16));
        for (int k = 0; k < 4; k++) expect_burst(32'h3100 + 32'(k * 64), 8'd16, 32'h400 + 32'(k * 16));
        d0 = done_cnt;
        start_job(32'h3000, 16'd128, 16'd1, 32'h0);
        push_pixels(32'h300, 64, 0);
        chk("t4_no_ovf_at_64", ovf, 0);
        push_pixels(32'h340, 1, 0);
        chk("t4_ovf_at_65", ovf, 1);
        b0 = beat_cnt;
        wr_bus.i_wire_wr_ack = 1'b1;
        wait_beats("t4_drain", b0 + 64, 300);
        push_pixels(32'h400, 64, 0);
        wait_done("t4_done", d0, 200);
        chk("t4_ovf_sticky", ovf, 1);

        // Zero-width job, then a start while busy.
        r0 = req_cycles;
        start_job(32'h5000, 16'd0, 16'd5, 32'h0);
        chk("t5_busy_t1", {busy, done, ovf}, 3'b100);
        tick();
        chk("t5_done_t2", {busy, done}, 2'b01);
        tick();
        chk("t5_done_once", done, 0);
        chk("t5_no_req", req_cycles - r0, 0);
        expect_burst(32'h6000, 8'd4, 32'h600);
        d0 = done_cnt;
        start_job(32'h6000, 16'd4, 16'd1, 32'h0);
        dst = 32'h7000; w = 16'd8; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_busy_second", busy, 1);
        push_pixels(32'h600, 4, 0);
        wait_done("t5_done", d0, 50);

        // Reset in the middle of a burst, then a fresh job.
        wr_bus.i_wire_wr_data_ready = 1'b0;
        expect_burst(32'h8000, 8'd16, 32'h700);
        for (int i = 0; i < 13; i++) void'(exp_dat.pop_back());
        start_job(32'h8000, 16'd16, 16'd1, 32'h40);
        push_pixels(32'h700, 16, 0);
        wait_valid("t6_valid", 20);
        b0 = beat_cnt;
        wr_bus.i_wire_wr_data_ready = 1'b1;
        tick(); tick(); tick();
        wr_bus.i_wire_wr_data_ready = 1'b0;
        chk("t6_three_beats", beat_cnt - b0, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_ctrl", {wr_bus.o_wire_wr_req, wr_bus.o_wire_wr_addr, wr_bus.o_wire_wr_len,
                              wr_bus.o_wire_wr_data_valid, busy, done, ovf}, 0);
        chk("t6_reset_data", wr_bus.o_wire_wr_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        wr_bus.i_wire_wr_data_ready = 1'b1;
        expect_burst(32'h10, 8'd2, 32'h800);
        d0 = done_cnt;
        start_job(32'h10, 16'd2, 16'd1, 32'h0);
        push_pixels(32'h800, 2, 0);
        wait_done("t6_fresh_done", d0, 50);

        chk("req_queue_empty", exp_req.size(), 0);
        chk("data_queue_empty", exp_dat.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
